// File: rtl/spi_master_frame.sv
// spi_master_frame
// SPI mode-0 initiator that clocks one full-duplex frame of BUFFER_SIZE bits
// (MSB first) out on mosi and captures the reply on miso. The first 32 bits
// of each received frame are compared against HEADER_RX.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous reset, active-high
//   start      frame request, only looked at while idle
//   tx_data    frame to send, latched when start is accepted
//   rx_data    last complete received frame
//   busy       high from the cycle after start accept through the gap
//   done       one-cycle pulse when rx_data updates
//   header_ok  received header matched HEADER_RX, updated with done
//   mosi/miso  serial data out/in (miso is not synchronised here)
//   sclk       SPI clock, idles low
//   sel        chip select, active-low
module spi_master_frame #(
  parameter int          BUFFER_SIZE = 32,
  parameter int          CLK_DIV     = 4,
  parameter logic [31:0] HEADER_RX   = 32'h61746164
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   header_ok,
  output logic                   mosi,
  input  logic                   miso,
  output logic                   sclk,
  output logic                   sel
);

  localparam int HC_W = $clog2(CLK_DIV);
  localparam int BC_W = $clog2(BUFFER_SIZE);
  localparam logic [HC_W-1:0] HC_LOAD = HC_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BUFFER_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL, S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [HC_W-1:0]        hc_q, hc_d;
  logic [BC_W-1:0]        bc_q, bc_d;
  logic [BUFFER_SIZE-1:0] tx_sr_q, tx_sr_d;
  logic [BUFFER_SIZE-1:0] rx_sr_q, rx_sr_d;
  logic [BUFFER_SIZE-1:0] rx_data_q, rx_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   header_ok_q, header_ok_d;
  logic                   mosi_q, mosi_d;
  logic                   sclk_q, sclk_d;
  logic                   sel_q, sel_d;
  logic                   hc_exit;

  assign hc_exit = (hc_q == '0);

  always_comb begin
    state_d     = state_q;
    hc_d        = hc_q;
    bc_d        = bc_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    header_ok_d = header_ok_q;
    mosi_d      = mosi_q;
    sclk_d      = sclk_q;
    sel_d       = sel_q;

    // Every timed state counts hc down to zero and leaves on that cycle.
    if (state_q != S_IDLE && !hc_exit) begin
      hc_d = hc_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_sr_d = tx_data;
          sel_d   = 1'b0;
          mosi_d  = tx_data[BUFFER_SIZE-1];
          busy_d  = 1'b1;
          bc_d    = '0;
          hc_d    = HC_LOAD;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (hc_exit) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[BUFFER_SIZE-2:0], miso};
          hc_d    = HC_LOAD;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (hc_exit) begin
          sclk_d = 1'b0;
          hc_d   = HC_LOAD;
          if (bc_q == BC_LAST) begin
            state_d = S_TRAIL;
          end else begin
            // Rotate rather than shift so the bit just sent is kept; mosi
            // takes the next bit as the new MSB on this falling edge.
            bc_d    = bc_q + 1'b1;
            tx_sr_d = {tx_sr_q[BUFFER_SIZE-2:0], tx_sr_q[BUFFER_SIZE-1]};
            mosi_d  = tx_sr_q[BUFFER_SIZE-2];
            state_d = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (hc_exit) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[BUFFER_SIZE-2:0], miso};
          hc_d    = HC_LOAD;
          state_d = S_HIGH;
        end
      end
      S_TRAIL: begin
        if (hc_exit) begin
          sel_d       = 1'b1;
          rx_data_d   = rx_sr_q;
          done_d      = 1'b1;
          header_ok_d = (rx_sr_q[BUFFER_SIZE-1 -: 32] == HEADER_RX);
          hc_d        = HC_LOAD;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (hc_exit) begin
          busy_d  = 1'b0;
          hc_d    = HC_LOAD;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hc_q        <= '0;
      bc_q        <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      header_ok_q <= 1'b0;
      mosi_q      <= 1'b0;
      sclk_q      <= 1'b0;
      sel_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      bc_q        <= bc_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      header_ok_q <= header_ok_d;
      mosi_q      <= mosi_d;
      sclk_q      <= sclk_d;
      sel_q       <= sel_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign header_ok = header_ok_q;
  assign mosi      = mosi_q;
  assign sclk      = sclk_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_spi_master_frame.sv
// Testbench for spi_master_frame (BUFFER_SIZE=32, CLK_DIV=4).
// The driver issues stimulus and, from a timing-level model of the frame,
// pushes the expected reply into a queue; the monitor compares the DUT pins
// every cycle and pops the queue whenever a done pulse is due.
module tb_spi_master_frame;

  localparam int          N        = 32;
  localparam int          D        = 4;
  localparam logic [31:0] HDR      = 32'h61746164;
  localparam int          SEL_END  = (2*N+1)*D;
  localparam int          BUSY_END = (2*N+2)*D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] tx_data;
  logic [N-1:0] rx_data;
  logic         busy, done, header_ok, mosi, miso_w, sclk, sel;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_frame #(.BUFFER_SIZE(N), .CLK_DIV(D), .HEADER_RX(HDR)) u_dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .done(done), .header_ok(header_ok),
    .mosi(mosi), .miso(miso_w), .sclk(sclk), .sel(sel)
  );

  // Far end: either a wire loopback or a slave that presents pat MSB first,
  // first bit at select and the next bit after every sclk fall.
  bit           loop_mode = 1'b1;
  logic [N-1:0] pat = '0;
  int           pidx = 0;
  logic         miso_pat;
  bit           s_sel_p = 1'b1;
  bit           s_sclk_p = 1'b0;

  assign miso_pat = (pidx >= 0 && pidx < N) ? pat[N-1-pidx] : 1'b0;
  assign miso_w   = loop_mode ? mosi : miso_pat;

  always @(posedge clk) begin
    #1;
    if (s_sel_p && !sel) pidx = 0;
    else if (s_sclk_p && !sclk) pidx = pidx + 1;
    s_sel_p  = sel;
    s_sclk_p = sclk;
  end

  // Reference model state
  typedef struct {
    logic [N-1:0] rx;
    logic         hok;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           acc = -100000;
  bit           live = 1'b0;
  logic [N-1:0] cur_tx = '0;
  int           free_at = 0;
  logic [N-1:0] rx_hold = '0;
  logic         hok_hold = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  // One input cycle; the model decides acceptance from the frame timing rules.
  task automatic drive(input bit st, input bit r, input logic [N-1:0] tx);
    exp_t e;
    @(negedge clk);
    start   = st;
    rst     = r;
    tx_data = tx;
    if (r) begin
      live     = 1'b0;
      acc      = -100000;
      exp_q.delete();
      rx_hold  = '0;
      hok_hold = 1'b0;
      free_at  = cyc + 1;
    end else if (st && cyc >= free_at) begin
      e.rx  = loop_mode ? tx : pat;
      e.hok = (e.rx[N-1 -: 32] == HDR);
      e.cyc = cyc + 1 + SEL_END;
      exp_q.push_back(e);
      acc     = cyc;
      live    = 1'b1;
      cur_tx  = tx;
      free_at = cyc + 1 + BUSY_END;
    end
  endtask

  task automatic wait_idle(input bit random_starts);
    while (cyc + 1 < free_at)
      drive(random_starts && ($urandom_range(7) == 0), 1'b0, N'($urandom));
  endtask

  // Monitor
  bit m_sel_p = 1'b1;
  bit m_sclk_p = 1'b0;
  int rises = 0;

  always @(posedge clk) begin
    int   rel, bi;
    bit   in_sel, in_busy, exp_sclk, exp_mosi, exp_done;
    exp_t e;
    #2;
    rel      = cyc - acc;
    in_sel   = live && rel >= 1 && rel <= SEL_END;
    in_busy  = live && rel >= 1 && rel <= BUSY_END;
    exp_sclk = in_sel && rel >= 1 + D && rel <= 2*N*D && (((rel - 1 - D) / D) % 2 == 0);
    if (in_busy) begin
      bi = (rel - 1) / (2*D);
      if (bi > N - 1) bi = N - 1;
      exp_mosi = cur_tx[N-1-bi];
    end else begin
      exp_mosi = live ? cur_tx[0] : 1'b0;
    end
    exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);

    if (m_sel_p && !sel) rises = 0;
    else if (!m_sclk_p && sclk) rises++;
    m_sel_p  = sel;
    m_sclk_p = sclk;

    chk("sel", 64'(sel), 64'(!in_sel));
    chk("busy", 64'(busy), 64'(in_busy));
    chk("sclk", 64'(sclk), 64'(exp_sclk));
    chk("mosi", 64'(mosi), 64'(exp_mosi));
    chk("done", 64'(done), 64'(exp_done));
    if (exp_done) begin
      e = exp_q.pop_front();
      chk("frame_rx", 64'(rx_data), 64'(e.rx));
      chk("frame_hok", 64'(header_ok), 64'(e.hok));
      chk("sclk_rises", 64'(rises), 64'(N));
      rx_hold  = e.rx;
      hok_hold = e.hok;
    end
    chk("rx_hold", 64'(rx_data), 64'(rx_hold));
    chk("hok_hold", 64'(header_ok), 64'(hok_hold));
  end

  initial begin
    logic [N-1:0] p;
    int base;
    rst     = 1'b1;
    start   = 1'b0;
    tx_data = '0;
    repeat (3) drive(1'b0, 1'b1, '0);

    // Loopback frame with starts at relative cycles 50 and 263 (ignored),
    // payload changed after acceptance.
    loop_mode = 1'b1;
    drive(1'b1, 1'b0, 32'hA5C3_0F81);
    base = acc;
    for (int k = 1; k <= BUSY_END; k++)
      drive((k == 50) || (k == 263), 1'b0, N'($urandom));
    // Start right after busy falls launches a new frame.
    drive(1'b1, 1'b0, N'($urandom));
    wait_idle(1'b0);

    // Slave presenting the header, then a non-matching reply.
    loop_mode = 1'b0;
    pat = HDR;
    drive(1'b1, 1'b0, N'($urandom));
    wait_idle(1'b0);
    p = N'($urandom);
    if (p[N-1 -: 32] == HDR) p[0] = ~p[0];
    pat = p;
    drive(1'b1, 1'b0, N'($urandom));
    wait_idle(1'b0);

    // Start held high: back-to-back frames.
    loop_mode = 1'b1;
    repeat (2 * (BUSY_END + 1)) drive(1'b1, 1'b0, N'($urandom));
    drive(1'b0, 1'b0, N'($urandom));
    wait_idle(1'b0);

    // Reset at relative cycle 100, then reset together with start.
    drive(1'b1, 1'b0, N'($urandom));
    repeat (99) drive(1'b0, 1'b0, N'($urandom));
    drive(1'b0, 1'b1, N'($urandom));
    drive(1'b1, 1'b1, N'($urandom));
    repeat (20) drive(1'b0, 1'b0, N'($urandom));

    // Random frames with stray start pulses while busy.
    repeat (4) begin
      loop_mode = ($urandom_range(1) == 1);
      p = N'($urandom);
      if ($urandom_range(1) == 1) p[N-1 -: 32] = HDR;
      pat = p;
      drive(1'b1, 1'b0, N'($urandom));
      wait_idle(1'b1);
    end
    repeat (5) drive(1'b0, 1'b0, N'($urandom));

    chk("pending_frames", 64'(exp_q.size()), 64'd0);
    if (base < 0) chk("first_accept", 64'(base), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_frame.md
Name: spi_master_frame

Overview:
- SPI initiator that drives one full-duplex frame of BUFFER_SIZE bits into the board's SPI slave interface and captures the reply.
- Used as the host-side end in loopback/self-test builds and for board-to-board links; talks to the slave over mosi/miso/sclk/sel.
- Checks the first 32 received bits against the expected "data" header word and flags the match.

Parameters:
- BUFFER_SIZE, 32, frame length in bits; integer ≥ 32.
- CLK_DIV, 4, SCLK half-period in clk cycles; integer ≥ 2. Use ≥ 4 with the 3-stage-synchronised slave.
- HEADER_RX, 32'h61746164, expected value of rx_data[BUFFER_SIZE-1 -: 32]. This is the slave's "data" header in byte-reversed wire order.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- start  in  1  frame request, sampled only in IDLE.
- tx_data  in  BUFFER_SIZE  frame to send; MSB first; latched on start accept.
- rx_data  out  BUFFER_SIZE  last complete received frame.
- busy  out  1  high from the cycle after start accept through the end of GAP.
- done  out  1  one-cycle pulse when rx_data updates.
- header_ok  out  1  registered compare result, updated with done.
- mosi  out  1  SPI data to slave.
- miso  in  1  SPI data from slave; not synchronised here.
- sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- sel  out  1  chip select, active-low.

Behaviour:
- All outputs are registered. Reset values: sel=1, sclk=0, mosi=0, busy=0, done=0, header_ok=0, rx_data=0. State=IDLE; counters and shift registers cleared.
- Half-period counter hc loads CLK_DIV-1 on every state entry. A state exits on the cycle hc==0.
- States and transitions:
  - IDLE: if start=1, latch tx_data into tx_sr, set sel<=0, mosi<=tx_data[MSB], busy<=1, bit counter bc<=0, go to LEAD.
  - LEAD: sel setup time, sclk=0. On exit: sclk<=1, rx_sr<={rx_sr, miso}, go to HIGH.
  - HIGH: on exit, sclk<=0. If bc==BUFFER_SIZE-1, go to TRAIL. Otherwise bc<=bc+1, tx_sr shifts left, mosi<=next bit, go to LOW.
  - LOW: on exit, sclk<=1, shift miso into rx_sr, go to HIGH.
  - TRAIL: on exit, sel<=1, rx_data<=rx_sr, done<=1 for one cycle, header_ok<=(rx_sr[BUFFER_SIZE-1 -: 32]==HEADER_RX), go to GAP.
  - GAP: deselect time, sel=1. On exit, busy<=0, go to IDLE.
- Data timing:
  - mosi changes only on sclk falling edges (or at sel assertion). It is stable for ≥ CLK_DIV cycles before each rising edge.
  - miso is sampled on the same clk edge that drives sclk high. This is the value present at the end of the low half.
- Cycle timing, with cycle 0 = start accepted and N=BUFFER_SIZE, D=CLK_DIV:
  - sel falls at cycle 1.
  - First sclk rise at 1+D.
  - Last sclk fall at 1+2N·D.
  - sel rises and done pulses at 1+(2N+1)·D.
  - busy falls at 1+(2N+2)·D.
  - Exactly N rising sclk edges per frame.
- Boundary conditions:
  - start while busy (including during GAP) is ignored; there is no queuing.
  - start held high continuously gives back-to-back frames separated by the GAP plus one IDLE cycle.
  - tx_data changes after acceptance do not affect the frame in flight.
  - rst mid-frame: next cycle sel=1, sclk=0, busy=0, no done pulse, rx_data=0, state IDLE. A partial frame is never published.
  - rst and start in the same cycle: rst wins.
  - rx_data and header_ok hold their values between frames.

Test Plan:
- Loopback (miso tied to mosi), N=32, D=4, tx_data=32'hA5C3_0F81 -> rx_data=32'hA5C3_0F81, done at cycle 261, busy low at cycle 265, 32 sclk rises, header_ok=0.
- Against the spi slave with ESTOP=0 -> first 32 rx bits = 32'h61746164, header_ok=1. Repeat with the slave in ESTOP -> header_ok=0.
- Pulse start at cycles 50 and 263 during the first frame -> both ignored, exactly one done pulse; a start after busy falls launches a new frame.
- Assert rst at cycle 100 mid-frame -> at cycle 101 sel=1, sclk=0, busy=0; done never pulses; rx_data=0.
- D=2, N=40, miso driven by a bench model shifting pattern 40'hF0_1234_5678 on sclk falling edges -> rx_data matches; every mosi transition coincides with an sclk fall.
